// File: rtl/crypto_test_oci_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crypto_test_oci_trace_pkg
// Description : Shared types and helpers for the OCI trace monitor. It holds
//               the monitor state encoding and the FIFO entry width, which is
//               the count tag and the trace word packed side by side.
// Revision    : 1.0  initial release
// ============================================================================
package crypto_test_oci_trace_pkg;

  // The encoding is visible on the state port, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_t;

  localparam int DEFAULT_CNT_W   = 4;
  localparam int DEFAULT_DCT_W   = 30;
  localparam int DEFAULT_ENTRY_W = DEFAULT_CNT_W + DEFAULT_DCT_W;

  // A FIFO entry is {dct_count, dct_buffer}.
  function automatic int entry_width(input int cnt_w, input int dct_w);
    return cnt_w + dct_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crypto_test_oci_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : crypto_test_oci_trace_fifo
// Description : Synchronous FIFO holding trace entries. The head entry is
//               presented combinationally, so a word written into an empty
//               FIFO is visible right after the write edge. The read port
//               shows zero when the FIFO is empty.
// Ports       : clk, reset (async, active high), clear (sync flush),
//               push/wdata (write request), pop (read request),
//               rdata (head entry), full, empty, level (occupancy).
// Revision    : 1.0  initial release
// ============================================================================
module crypto_test_oci_trace_fifo
  import crypto_test_oci_trace_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_ENTRY_W,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);

  // A pop is only meaningful when there is a head entry; a push into a full
  // FIFO is only possible when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; validity is tracked by the level counter.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are ADDR_W bits wide and DEPTH is a power of two, so they wrap
  // modulo DEPTH naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (ADDR_W + 1)'(1);
        2'b01:   level <= level - (ADDR_W + 1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/crypto_test_nios2_qsys_0_oci_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : crypto_test_nios2_qsys_0_oci_trace_monitor
// Description : Captures debug trace words into a FIFO while armed, drains
//               them to a ready/valid consumer at the end of a test, and
//               keeps saturating capture/drop statistics.
// Ports       : clk, reset (async, active high), enable (arm), clear (sync
//               flush), dct_valid/dct_buffer/dct_count (trace input),
//               test_ending/test_has_ended (end-of-test events),
//               out_valid/out_ready/out_data (FIFO head stream),
//               captured/dropped/overflow (statistics), state, done.
// Revision    : 1.0  initial release
// ============================================================================
module crypto_test_nios2_qsys_0_oci_trace_monitor
  import crypto_test_oci_trace_pkg::*;
#(
  parameter int DCT_W  = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int STAT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     dct_valid,
  input  logic [DCT_W-1:0]         dct_buffer,
  input  logic [CNT_W-1:0]         dct_count,
  input  logic                     test_ending,
  input  logic                     test_has_ended,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W+DCT_W-1:0]   out_data,
  output logic [STAT_W-1:0]        captured,
  output logic [STAT_W-1:0]        dropped,
  output logic                     overflow,
  output logic [1:0]               state,
  output logic                     done
);

  localparam int ENTRY_W = entry_width(CNT_W, DCT_W);
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  trace_state_t       state_q;
  trace_state_t       state_d;
  logic               ended_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic [LVL_W-1:0]   fifo_level;

  logic               push_req;
  logic               pop_ok;
  logic               push_ok;
  logic               drop;
  logic               going_empty;

  // Push eligibility is based on the current state, so a word that arrives
  // on the cycle the FSM leaves CAPTURE is still captured.
  assign push_req = (state_q == ST_CAPTURE) && dct_valid;
  assign pop_ok   = !fifo_empty && out_ready;
  assign push_ok  = push_req && (!fifo_full || pop_ok);
  assign drop     = push_req && fifo_full && !pop_ok;

  // FIFO is empty after this edge: already empty, or the last entry leaves
  // now with nothing replacing it. This lets DONE follow the final pop
  // directly instead of one cycle later.
  assign going_empty = fifo_empty ||
                       ((fifo_level == LVL_W'(1)) && pop_ok && !push_ok);

  crypto_test_oci_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push_ok),
    .pop   (pop_ok),
    .wdata ({dct_count, dct_buffer}),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign state     = state_q;
  assign done      = (state_q == ST_DONE);

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else if (clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // End-of-test takes precedence over disarming so that the trace is
        // always drained once the test signals its end.
        if (test_ending || test_has_ended) begin
          state_d = ST_DRAIN;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (going_empty && (ended_q || test_has_ended)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sticky end-of-test flag, overflow flag and saturating statistics
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ended_q  <= 1'b0;
      overflow <= 1'b0;
      captured <= '0;
      dropped  <= '0;
    end else if (clear) begin
      ended_q  <= 1'b0;
      overflow <= 1'b0;
      captured <= '0;
      dropped  <= '0;
    end else begin
      if (test_has_ended) begin
        ended_q <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (push_ok && (captured != '1)) begin
        captured <= captured + STAT_W'(1);
      end
      if (drop && (dropped != '1)) begin
        dropped <= dropped + STAT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crypto_test_nios2_qsys_0_oci_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_crypto_test_nios2_qsys_0_oci_trace_monitor
// Description : Directed bench for the OCI trace monitor. A second instance
//               with 2-bit statistics shares the stimulus to exercise
//               counter saturation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_crypto_test_nios2_qsys_0_oci_trace_monitor;

  localparam int DCT_W = 30;
  localparam int CNT_W = 4;
  localparam int EW    = CNT_W + DCT_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             clear;
  logic             dct_valid;
  logic [DCT_W-1:0] dct_buffer;
  logic [CNT_W-1:0] dct_count;
  logic             test_ending;
  logic             test_has_ended;
  logic             out_ready;

  logic             out_valid;
  logic [EW-1:0]    out_data;
  logic [15:0]      captured;
  logic [15:0]      dropped;
  logic             overflow;
  logic [1:0]       state;
  logic             done;

  logic             s_out_valid;
  logic [EW-1:0]    s_out_data;
  logic [1:0]       s_captured;
  logic [1:0]       s_dropped;
  logic             s_overflow;
  logic [1:0]       s_state;
  logic             s_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  crypto_test_nios2_qsys_0_oci_trace_monitor #(
    .DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(16), .STAT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .dct_valid(dct_valid), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .captured(captured), .dropped(dropped), .overflow(overflow),
    .state(state), .done(done)
  );

  crypto_test_nios2_qsys_0_oci_trace_monitor #(
    .DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(16), .STAT_W(2)
  ) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .dct_valid(dct_valid), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .captured(s_captured), .dropped(s_dropped), .overflow(s_overflow),
    .state(s_state), .done(s_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: land 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] ent(input int c, input int b);
    logic [CNT_W-1:0] cc;
    logic [DCT_W-1:0] bb;
    cc = c[CNT_W-1:0];
    bb = b[DCT_W-1:0];
    return {cc, bb};
  endfunction

  task automatic drive(input int c, input int b);
    dct_valid  = 1'b1;
    dct_count  = c[CNT_W-1:0];
    dct_buffer = b[DCT_W-1:0];
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; dct_valid = 1'b0;
    dct_buffer = '0; dct_count = '0; test_ending = 1'b0;
    test_has_ended = 1'b0; out_ready = 1'b0;

    // ---------------- reset state ----------------
    cyc(); cyc();
    check("rst_state", state, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_captured", captured, 0);
    check("rst_dropped", dropped, 0);
    check("rst_overflow", overflow, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    enable = 1'b1;

    // ---------------- three ordered pushes, consumer ready ----------------
    cyc();
    check("t1_state_capture", state, 1);
    out_ready = 1'b1;
    drive(1, 1);
    cyc();
    check("t1_valid1", out_valid, 1);
    check("t1_data1", out_data, ent(1, 1));
    drive(2, 2);
    cyc();
    check("t1_data2", out_data, ent(2, 2));
    drive(3, 3);
    cyc();
    check("t1_data3", out_data, ent(3, 3));
    dct_valid = 1'b0;
    cyc();
    check("t1_empty", out_valid, 0);
    check("t1_captured", captured, 3);
    check("t1_sat_captured", s_captured, 3);

    // ---------------- overflow: 20 pushes into 16 entries ----------------
    clear = 1'b1; out_ready = 1'b0;
    cyc();
    check("t2_clear_state", state, 0);
    check("t2_clear_captured", captured, 0);
    clear = 1'b0;
    cyc();
    for (int i = 0; i < 20; i++) begin
      drive(i, 256 + i);
      cyc();
    end
    dct_valid = 1'b0;
    check("t2_captured", captured, 16);
    check("t2_dropped", dropped, 4);
    check("t2_overflow", overflow, 1);
    check("t2_head", out_data, ent(0, 256));

    // ---------------- full FIFO, push and pop in one cycle ----------------
    out_ready = 1'b1;
    drive(10, 938);
    cyc();
    dct_valid = 1'b0;
    check("t3_dropped_same", dropped, 4);
    check("t3_captured", captured, 17);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("t2_pop%0d", i), out_data, ent(i, 256 + i));
      cyc();
    end
    check("t3_pop_new", out_data, ent(10, 938));
    cyc();
    check("t2_drained", out_valid, 0);

    // ---------------- end-of-test drain ----------------
    clear = 1'b1; out_ready = 1'b0;
    cyc();
    check("t4_clear_overflow", overflow, 0);
    clear = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      drive(i + 5, 512 + i);
      cyc();
    end
    drive(9, 516);
    test_ending = 1'b1;
    cyc();
    test_ending = 1'b0;
    check("t4_state_drain", state, 2);
    check("t4_captured5", captured, 5);
    // Still strobing in DRAIN: nothing is captured.
    drive(15, 999);
    test_has_ended = 1'b1;
    cyc();
    test_has_ended = 1'b0;
    dct_valid = 1'b0;
    check("t4_no_push_drain", captured, 5);
    check("t4_not_done", done, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_pop%0d", i), out_data, ent(i + 5, 512 + i));
      if (i == 4) check("t4_done_before_last", done, 0);
      cyc();
    end
    check("t4_done", done, 1);
    check("t4_state_done", state, 3);
    enable = 1'b0;
    cyc(); cyc();
    check("t4_done_hold", state, 3);
    enable = 1'b1;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("t4_clear_idle", state, 0);

    // ---------------- async reset with 8 entries queued ----------------
    out_ready = 1'b0;
    cyc();
    for (int i = 0; i < 8; i++) begin
      drive(i, 768 + i);
      cyc();
    end
    dct_valid = 1'b0;
    check("t5_queued", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_valid", out_valid, 0);
    check("t5_async_captured", captured, 0);
    check("t5_async_state", state, 0);
    check("t5_async_data", out_data, 0);
    cyc();
    reset = 1'b0;

    // ---------------- saturation on the 2-bit instance ----------------
    cyc();
    check("t6_state_capture", s_state, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(i, 64 + i);
      cyc();
    end
    dct_valid = 1'b0;
    check("t6_main_captured", captured, 5);
    check("t6_sat_captured", s_captured, 3);
    check("t6_sat_dropped", s_dropped, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crypto_test_nios2_qsys_0_oci_trace_monitor.md
CRYPTO_TEST_NIOS2_QSYS_0_OCI_TRACE_MONITOR -- requirements
Module: crypto_test_nios2_qsys_0_oci_trace_monitor

Interface
REQ-001 SHALL provide parameter DCT_W, default 30, width of the debug capture trace (DCT) word.
REQ-002 SHALL provide parameter CNT_W, default 4, width of the DCT count tag.
REQ-003 SHALL provide parameter DEPTH, default 16, FIFO entries; power of two, minimum 2.
REQ-004 SHALL provide parameter STAT_W, default 16, width of the capture and drop counters.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 Port: clk  in  1  rising-edge clock.
REQ-007 Port: reset  in  1  asynchronous active-high reset.
REQ-008 Port: enable  in  1  level; arms capture.
REQ-009 Port: clear  in  1  synchronous one-cycle flush of FIFO, counters and state.
REQ-010 Port: dct_valid  in  1  DCT word strobe.
REQ-011 Port: dct_buffer  in  DCT_W  trace word.
REQ-012 Port: dct_count  in  CNT_W  trace count tag.
REQ-013 Port: test_ending  in  1  end-of-test warning.
REQ-014 Port: test_has_ended  in  1  end-of-test final.
REQ-015 Port: out_valid  out  1  FIFO head valid.
REQ-016 Port: out_ready  in  1  consumer accept.
REQ-017 Port: out_data  out  CNT_W+DCT_W  {dct_count, dct_buffer} of head entry.
REQ-018 Port: captured  out  STAT_W  accepted-word count, saturating.
REQ-019 Port: dropped  out  STAT_W  dropped-word count, saturating.
REQ-020 Port: overflow  out  1  sticky: at least one word dropped.
REQ-021 Port: state  out  2  current state encoding.
REQ-022 Port: done  out  1  high in DONE.

Function
REQ-023 States SHALL be IDLE=0, CAPTURE=1, DRAIN=2, DONE=3.
REQ-024 IDLE->CAPTURE SHALL occur when enable=1; CAPTURE->IDLE SHALL occur when enable=0; FIFO contents are retained.
REQ-025 CAPTURE->DRAIN SHALL occur when test_ending=1 or test_has_ended=1; test_has_ended SHALL be latched into a sticky ended flag in any state.
REQ-026 DRAIN->DONE SHALL occur when the FIFO is empty and the ended flag is set; DONE SHALL hold until clear or reset.
REQ-027 Push SHALL occur only in CAPTURE with dct_valid=1; a word arriving on the transition cycle out of CAPTURE SHALL still be pushed.
REQ-028 A pushed word SHALL appear at out_data/out_valid one cycle after the push cycle when the FIFO was empty.
REQ-029 Pop SHALL occur when out_valid=1 and out_ready=1; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-030 Push while full SHALL be accepted only if a pop occurs in the same cycle; otherwise the word SHALL be dropped, dropped incremented and overflow set.
REQ-031 Simultaneous push and pop on an empty FIFO SHALL push only; nothing is popped.
REQ-032 captured and dropped SHALL saturate at 2^STAT_W-1 with no wrap; FIFO pointers SHALL wrap modulo DEPTH.
REQ-033 clear SHALL take priority over all events: empty FIFO, zero counters, clear overflow and the ended flag, and enter IDLE next cycle.

Reset
REQ-034 Reset SHALL force state=IDLE, out_valid=0, out_data=0, captured=0, dropped=0, overflow=0, done=0, ended flag=0, and FIFO empty.
REQ-035 Reset asserted mid-operation SHALL discard all FIFO contents immediately; the first push SHALL be possible the cycle after deassertion if enable=1.

Structure
REQ-036 Package crypto_test_oci_trace_pkg SHALL hold the state enum and the entry-width constant/function (CNT_W+DCT_W).
REQ-037 FIFO storage and pointers SHALL be sub-module crypto_test_oci_trace_fifo (parametrised width/depth, full/empty, async active-high reset).

Verification
REQ-038 Bench: reset, enable=1, 3 pushes {1,0x1}, {2,0x2}, {3,0x3}, out_ready=1 -> 3 ordered outputs, each 1 cycle after push, captured=3.
REQ-039 Bench: DEPTH=16, out_ready=0, 20 pushes -> 16 stored, dropped=4, overflow=1, then 16 pops in order.
REQ-040 Bench: full FIFO with push and pop in one cycle -> push accepted, dropped unchanged.
REQ-041 Bench: test_ending mid-stream, then test_has_ended, 5 entries queued -> DRAIN; done=1 the cycle after the 5th pop.
REQ-042 Bench: reset asserted with 8 entries queued -> out_valid=0 asynchronously, counters 0, state IDLE.
REQ-043 Bench: STAT_W=2, 5 accepted pushes -> captured saturates at 3.
